tcam_match_encoder: RTL
=======================

# tcam_match_encoder

Downstream stage of `Total_tcam`. It captures the 120-bit per-rule match vector `result` on every lookup (`readen`=1) and reduces it through a pipelined priority encoder to a hit flag, the lowest matching rule index and a multi-match flag. Each response is tagged with its lookup key and queued in a 4-deep response FIFO, so the action-table stage can apply valid/ready backpressure. The TCAM itself cannot be stalled.

## Interface
- `N_RULES`, 120, number of rules / width of the match vector
- `IDX_W`, 7, index width; must satisfy 2^IDX_W >= N_RULES
- `KEY_W`, 104, lookup key width
- `write_clk` in 1: single clock, shared with the TCAM
- `resetn` in 1: asynchronous, active-low reset
- `readen` in 1: lookup strobe, the same signal driving the TCAM; `result`/`key` are sampled when it is 1
- `result` in N_RULES: match vector, bit i = rule i matched
- `key` in KEY_W: key of the current lookup
- `out_valid` out 1: FIFO head holds a response
- `out_ready` in 1: consumer accepts the head
- `out_hit` out 1: at least one rule matched
- `out_idx` out IDX_W: lowest matching rule index; 0 on miss
- `out_multi` out 1: two or more rules matched
- `out_key` out KEY_W: key of this response
- `ovf` out 1: sticky flag, a response was dropped

## Operation
- **S1 (capture):** on a clock edge with `readen`=1, register `result`, `key` and `v1`=1. Otherwise `v1`=0 and the data registers hold.
- **S2 (group encode):** split the vector into 8 groups of 16 bits, bits [16g+15:16g]. Group 7 is bits [119:112], with the upper 8 bits treated as 0.
  - Per group, register: any-hit `gh[g]`, local lowest index `li[g]` (4 b) and a group multi-flag `gm[g]`.
  - Also register `key` and `v2`=`v1`.
- **S3 (final encode):**
  - g* = lowest g with `gh[g]`=1; `idx` = 16·g* + `li[g*]`.
  - `hit` = OR of `gh`.
  - `multi` = (OR of `gm`) OR (popcount(`gh`) >= 2).
  - If `v2`=1, push {hit, idx, multi, key} into the FIFO.
- **Miss:** `hit`=0, `idx`=0, `multi`=0. A miss is still pushed; every lookup yields exactly one response.
- **FIFO:** 4 entries, fall-through. The head drives the `out_*` ports and `out_valid` = not empty. A pop occurs on `out_valid`&`out_ready`.
- **Full and no pop:** the S3 push is dropped and `ovf` sets to 1. `ovf` clears only on reset.
- **Full with simultaneous pop:** the push is accepted and nothing is dropped.
- **Empty with a push in the same cycle:** no pop occurs; `out_valid` rises after that edge.
- **Wrap-around:** read and write pointers are 2 bits plus a wrap bit. Full = pointers equal with the wrap bits differing.
- **Output stability:** `out_*` values are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset:** reset asserted (asynchronously) clears `v1`, `v2`, the FIFO pointers and `ovf`. All outputs read 0: `out_valid`, `out_hit`, `out_idx`, `out_multi`, `out_key`, `ovf`. Data registers need no reset.
- **Latency:** lookup sampled at edge E. S2 is registered at E+1 and the FIFO write happens at E+2. With the FIFO empty, `out_valid`=1 after E+2: 3 cycles from the `readen` cycle to the response.
- **Throughput:** one lookup per cycle. Back-to-back `readen` with `out_ready`=1 yields back-to-back responses in order.
- **Reset mid-operation:** in-flight S1/S2 lookups and all queued responses are discarded. No partial response appears after `resetn` deasserts.

## Configuration
- **`TCAM_MATCH_CNT_EN` defined:** adds port `out_cnt` (out, IDX_W+1 bits), the popcount of the match vector.
  - Per-group 5-bit counts are registered in S2 and summed in S3.
  - The count is stored in the FIFO alongside the other fields.
  - Reset value is 0; on a miss it reads 0.
- **Not defined:** the port, the count logic and the extra FIFO width are absent. `out_multi` is unaffected.

## Test plan
- Reset, then a single lookup with `result` = bit 37 only and `key`=0x1234, `out_ready`=1 → after 3 cycles: `out_valid`=1, `out_hit`=1, `out_idx`=37, `out_multi`=0, `out_key`=0x1234.
- `result` = bits 119, 64 and 5 → `out_idx`=5, `out_multi`=1; `out_cnt`=3 when `TCAM_MATCH_CNT_EN` is defined.
- `result`=0 → `out_hit`=0, `out_idx`=0, `out_multi`=0, and a response is still produced.
- `out_ready`=0, 6 consecutive lookups with single-bit vectors at bits 0..5 → responses for indices 0,1,2,3 retained and `ovf`=1. Raising `out_ready` drains 0,1,2,3 in order, then `out_valid`=0.
- FIFO full with `out_ready`=1 while a new lookup arrives → no drop, `ovf` stays 0, order preserved.
- Assert `resetn`=0 with 2 lookups in flight and 3 queued → all outputs 0 immediately. After release, no stale responses appear.

Source files
------------

// File: rtl/tcam_match_encoder.sv
// Pipelined priority encoder behind the TCAM: capture -> 16-bit group encode -> final encode -> 4-deep response FIFO.
// Optional match-count output `out_cnt` is enabled by defining TCAM_MATCH_CNT_EN.
module tcam_match_encoder #(
  parameter int N_RULES = 120,
  parameter int IDX_W   = 7,
  parameter int KEY_W   = 104
) (
  input  logic               write_clk,
  input  logic               resetn,
  input  logic               readen,
  input  logic [N_RULES-1:0] result,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_multi,
  output logic [KEY_W-1:0]   out_key,
  output logic               ovf
`ifdef TCAM_MATCH_CNT_EN
  ,
  output logic [IDX_W:0]     out_cnt
`endif
);

  localparam int NG    = (N_RULES + 15) / 16;
  localparam int PAD   = NG * 16;
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             multi;
    logic [KEY_W-1:0] key;
`ifdef TCAM_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;
`endif
  } entry_t;

  // ---------------- S1: capture ----------------
  logic               v1;
  logic [N_RULES-1:0] r1;
  logic [KEY_W-1:0]   k1;

  always_ff @(posedge write_clk or negedge resetn) begin
    if (!resetn) v1 <= 1'b0;
    else         v1 <= readen;
  end

  // NOTE: datapath registers carry no reset; only the valid bits and pointers
  // decide whether their contents are ever observed.
  always_ff @(posedge write_clk) begin
    if (readen) begin
      r1 <= result;
      k1 <= key;
    end
  end

  // ---------------- S2: group encode ----------------
  logic [PAD-1:0] r1_pad;
  logic [NG-1:0]  gh_d, gm_d, gh, gm;
  logic [3:0]     li_d [NG];
  logic [3:0]     li   [NG];
  logic [KEY_W-1:0] k2;
  logic           v2;
`ifdef TCAM_MATCH_CNT_EN
  logic [4:0]     gc_d [NG];
  logic [4:0]     gc   [NG];
`endif

  assign r1_pad = PAD'(r1);

  // NOTE: every always_comb output gets a default before the loops so no latch is inferred.
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      logic [15:0] grp;
      grp     = r1_pad[g*16 +: 16];
      gh_d[g] = |grp;
      gm_d[g] = |(grp & (grp - 16'd1));
      li_d[g] = 4'd0;
      for (int b = 15; b >= 0; b--)
        if (grp[b]) li_d[g] = 4'(b);
`ifdef TCAM_MATCH_CNT_EN
      gc_d[g] = 5'd0;
      for (int b = 0; b < 16; b++)
        gc_d[g] = gc_d[g] + 5'(grp[b]);
`endif
    end
  end

  always_ff @(posedge write_clk or negedge resetn) begin
    if (!resetn) v2 <= 1'b0;
    else         v2 <= v1;
  end

  always_ff @(posedge write_clk) begin
    gh <= gh_d;
    gm <= gm_d;
    li <= li_d;
    k2 <= k1;
`ifdef TCAM_MATCH_CNT_EN
    gc <= gc_d;
`endif
  end

  // ---------------- S3: final encode ----------------
  entry_t s3;

  always_comb begin
    s3       = '0;
    s3.key   = k2;
    s3.hit   = |gh;
    // multiple rules matched either inside one group or across groups
    s3.multi = (|gm) || ((gh & (gh - NG'(1))) != '0);
    for (int g = NG - 1; g >= 0; g--)
      if (gh[g]) s3.idx = IDX_W'(g * 16 + int'(li[g]));
`ifdef TCAM_MATCH_CNT_EN
    for (int g = 0; g < NG; g++)
      s3.cnt = s3.cnt + CNT_W'(gc[g]);
`endif
  end

  // ---------------- response FIFO ----------------
  entry_t     mem [4];
  logic [2:0] wp, rp;
  logic       empty, full, pop, do_push;
  entry_t     head;

  assign empty   = (wp == rp);
  assign full    = (wp[1:0] == rp[1:0]) && (wp[2] != rp[2]);
  assign pop     = !empty && out_ready;
  // a full FIFO still accepts when the head leaves on the same edge
  assign do_push = v2 && (!full || pop);

  always_ff @(posedge write_clk) begin
    if (do_push) mem[wp[1:0]] <= s3;
  end

  always_ff @(posedge write_clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= 3'd0;
      rp  <= 3'd0;
      ovf <= 1'b0;
    end else begin
      if (do_push)            wp  <= wp + 3'd1;
      if (pop)                rp  <= rp + 3'd1;
      if (v2 && full && !pop) ovf <= 1'b1;
    end
  end

  // head fields are gated so the outputs read zero when empty or in reset
  assign head      = mem[rp[1:0]];
  assign out_valid = !empty;
  assign out_hit   = out_valid & head.hit;
  assign out_idx   = out_valid ? head.idx : '0;
  assign out_multi = out_valid & head.multi;
  assign out_key   = out_valid ? head.key : '0;
`ifdef TCAM_MATCH_CNT_EN
  assign out_cnt   = out_valid ? head.cnt : '0;
`endif

endmodule
